// File: rtl/rv_tcm_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rv_tcm_ctrl_if                                               |
// | Description : Bus bundle for the rv TCM. Port A is the instruction-fetch   |
// |               port and port B is the data port. Both use req/gnt/rvalid.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface rv_tcm_ctrl_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned BE_W = DATA_W / 8;

  // Port A: instruction fetch, read-only
  logic              a_req;
  logic [ADDR_W-1:0] a_addr;
  logic              a_gnt;
  logic              a_rvalid;
  logic [DATA_W-1:0] a_rdata;
  logic              a_err;

  // Port B: data, read/write with byte strobes
  logic              b_req;
  logic              b_we;
  logic [BE_W-1:0]   b_be;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_wdata;
  logic              b_gnt;
  logic              b_rvalid;
  logic [DATA_W-1:0] b_rdata;
  logic              b_err;

  // Requester side (core / testbench)
  modport master (
    output a_req, a_addr,
    input  a_gnt, a_rvalid, a_rdata, a_err,
    output b_req, b_we, b_be, b_addr, b_wdata,
    input  b_gnt, b_rvalid, b_rdata, b_err
  );

  // Memory side
  modport slave (
    input  a_req, a_addr,
    output a_gnt, a_rvalid, a_rdata, a_err,
    input  b_req, b_we, b_be, b_addr, b_wdata,
    output b_gnt, b_rvalid, b_rdata, b_err
  );
endinterface
`default_nettype wire

// File: rtl/rv_tcm_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rv_tcm_ctrl                                                  |
// | Description : Single-ported tightly-coupled memory shared by a fetch port  |
// |               (A) and a data port (B). B has priority; a starvation        |
// |               counter forces an A grant after MAX_STALL denied cycles.     |
// |               Responses come back READ_LAT cycles after the grant.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module rv_tcm_ctrl #(
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       DEPTH     = 256,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int unsigned       READ_LAT  = 1,
  parameter int unsigned       MAX_STALL = 4,
  parameter string             INIT_FILE = ""
) (
  input  wire           clk_i,
  input  wire           rst_i,
  rv_tcm_ctrl_if.slave  bus
);

  localparam int unsigned       BE_W       = DATA_W / 8;
  localparam int unsigned       OFF_W      = $clog2(BE_W);
  localparam int unsigned       IDX_W      = $clog2(DEPTH);
  localparam int unsigned       CNT_W      = $clog2(MAX_STALL + 1);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(BE_W - 1);
  localparam logic [ADDR_W-1:0] DEPTH_A    = ADDR_W'(DEPTH);
  localparam logic [CNT_W-1:0]  STALL_MAX  = CNT_W'(MAX_STALL);

  // Storage (never reset)
  logic [DATA_W-1:0] mem_q [DEPTH];

  // Arbitration and decode of the single winning access
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic              a_gnt, b_gnt;
  logic [ADDR_W-1:0] sel_addr, sel_off;
  logic              sel_fault;
  logic [IDX_W-1:0]  sel_idx;
  logic [DATA_W-1:0] rd_word;
  logic              wr_en_d;
  logic [DATA_W-1:0] wr_word_d;

  // Response pipelines, stage READ_LAT-1 drives the outputs
  logic [READ_LAT-1:0] a_vld_q, a_vld_d, a_err_q, a_err_d;
  logic [READ_LAT-1:0] b_vld_q, b_vld_d, b_err_q, b_err_d;
  logic [DATA_W-1:0]   a_dat_q [READ_LAT];
  logic [DATA_W-1:0]   a_dat_d [READ_LAT];
  logic [DATA_W-1:0]   b_dat_q [READ_LAT];
  logic [DATA_W-1:0]   b_dat_d [READ_LAT];

  // Grant, address decode, starvation counter and merged write word
  always_comb begin
    b_gnt       = bus.b_req & ~(bus.a_req & (stall_cnt_q == STALL_MAX));
    a_gnt       = bus.a_req & ~b_gnt;

    // Only the granted port touches the array, so one decoder suffices.
    sel_addr    = b_gnt ? bus.b_addr : bus.a_addr;
    sel_off     = (sel_addr - BASE_ADDR) >> OFF_W;
    sel_fault   = (sel_addr < BASE_ADDR) | (sel_off >= DEPTH_A) |
                  ((sel_addr & ALIGN_MASK) != '0);
    sel_idx     = sel_off[IDX_W-1:0];
    rd_word     = mem_q[sel_idx];

    stall_cnt_d = stall_cnt_q;
    if (!bus.a_req || a_gnt) begin
      stall_cnt_d = '0;
    end else if (b_gnt && (stall_cnt_q != STALL_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end

    // Unselected bytes keep their current value, so be==0 writes back unchanged.
    wr_en_d   = b_gnt & bus.b_we & ~sel_fault;
    wr_word_d = rd_word;
    for (int k = 0; k < BE_W; k++) begin
      if (bus.b_be[k]) begin
        wr_word_d[k*8 +: 8] = bus.b_wdata[k*8 +: 8];
      end
    end
  end

  // Next state of the response shift registers; data/err only move with a valid
  always_comb begin
    a_vld_d    = '0;
    a_err_d    = a_err_q;
    b_vld_d    = '0;
    b_err_d    = b_err_q;
    a_dat_d    = a_dat_q;
    b_dat_d    = b_dat_q;

    a_vld_d[0] = a_gnt;
    b_vld_d[0] = b_gnt;
    if (a_gnt) begin
      a_err_d[0] = sel_fault;
      a_dat_d[0] = sel_fault ? '0 : rd_word;
    end
    if (b_gnt) begin
      b_err_d[0] = sel_fault;
      b_dat_d[0] = (sel_fault || bus.b_we) ? '0 : rd_word;
    end

    for (int s = 1; s < READ_LAT; s++) begin
      a_vld_d[s] = a_vld_q[s-1];
      b_vld_d[s] = b_vld_q[s-1];
      if (a_vld_q[s-1]) begin
        a_err_d[s] = a_err_q[s-1];
        a_dat_d[s] = a_dat_q[s-1];
      end
      if (b_vld_q[s-1]) begin
        b_err_d[s] = b_err_q[s-1];
        b_dat_d[s] = b_dat_q[s-1];
      end
    end
  end

  // Control and response registers; reset drops every outstanding response
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
      a_vld_q     <= '0;
      a_err_q     <= '0;
      b_vld_q     <= '0;
      b_err_q     <= '0;
      a_dat_q     <= '{default: '0};
      b_dat_q     <= '{default: '0};
    end else begin
      stall_cnt_q <= stall_cnt_d;
      a_vld_q     <= a_vld_d;
      a_err_q     <= a_err_d;
      b_vld_q     <= b_vld_d;
      b_err_q     <= b_err_d;
      a_dat_q     <= a_dat_d;
      b_dat_q     <= b_dat_d;
    end
  end

  // Array write at the grant edge
  always_ff @(posedge clk_i) begin
    if (wr_en_d) begin
      mem_q[sel_idx] <= wr_word_d;
    end
  end

  assign bus.a_gnt    = a_gnt;
  assign bus.b_gnt    = b_gnt;
  assign bus.a_rvalid = a_vld_q[READ_LAT-1];
  assign bus.a_err    = a_vld_q[READ_LAT-1] & a_err_q[READ_LAT-1];
  assign bus.a_rdata  = a_dat_q[READ_LAT-1];
  assign bus.b_rvalid = b_vld_q[READ_LAT-1];
  assign bus.b_err    = b_vld_q[READ_LAT-1] & b_err_q[READ_LAT-1];
  assign bus.b_rdata  = b_dat_q[READ_LAT-1];

endmodule
`default_nettype wire

// File: tb/tb_rv_tcm_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module      : tb_rv_tcm_ctrl                                               |
// | Description : Randomised scoreboard bench for rv_tcm_ctrl with a word-array|
// |               reference model and a separate response monitor.             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_rv_tcm_ctrl;

  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 256;
  localparam int unsigned RL    = 3;
  localparam int unsigned MS    = 4;
  localparam logic [31:0] BASE  = 32'h0000_1000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  rv_tcm_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  rv_tcm_ctrl #(
    .ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .BASE_ADDR(BASE),
    .READ_LAT(RL), .MAX_STALL(MS), .INIT_FILE("")
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    logic        err;
    longint      due;
  } rsp_t;

  rsp_t        qa[$];
  rsp_t        qb[$];
  logic [31:0] ref_mem [DEPTH];
  int unsigned deny_cnt = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic bit addr_bad(input logic [31:0] a);
    return (a < BASE) || (a >= BASE + DEPTH * 4) || (a[1:0] != 2'b00);
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  function automatic logic [31:0] rand_addr(input int unsigned span);
    int unsigned s;
    s = $urandom_range(0, 15);
    if (s == 0) return BASE - 32'd4;
    if (s == 1) return BASE + 32'(DEPTH * 4) + 32'(4 * $urandom_range(0, 7));
    if (s == 2) return BASE + 32'(4 * $urandom_range(0, span - 1)) + 32'($urandom_range(1, 3));
    return BASE + 32'(4 * $urandom_range(0, span - 1));
  endfunction

  // One request cycle: drive, check grants against the model, queue expectations.
  task automatic drive(input bit ar, input logic [31:0] aa, input bit br, input bit bw,
                       input logic [3:0] be, input logic [31:0] ba, input logic [31:0] wd);
    bit   ea, eb;
    rsp_t r;
    @(negedge clk);
    bus.a_req = ar; bus.a_addr = aa;
    bus.b_req = br; bus.b_we = bw; bus.b_be = be; bus.b_addr = ba; bus.b_wdata = wd;
    #1;
    eb = br && !(ar && deny_cnt >= MS);
    ea = ar && !eb;
    chk("a_gnt", 64'(bus.a_gnt), 64'(ea));
    chk("b_gnt", 64'(bus.b_gnt), 64'(eb));
    if (ea) begin
      r.err  = addr_bad(aa);
      r.data = r.err ? 32'h0 : ref_mem[widx(aa)];
      r.due  = cyc + RL;
      qa.push_back(r);
    end
    if (eb) begin
      r.err  = addr_bad(ba);
      r.data = (r.err || bw) ? 32'h0 : ref_mem[widx(ba)];
      r.due  = cyc + RL;
      if (!r.err && bw) begin
        for (int k = 0; k < 4; k++)
          if (be[k]) ref_mem[widx(ba)][k*8 +: 8] = wd[k*8 +: 8];
      end
      qb.push_back(r);
    end
    deny_cnt = (ar && !ea) ? deny_cnt + 1 : 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_a_rvalid", 64'(bus.a_rvalid), 64'd0);
    chk("rst_b_rvalid", 64'(bus.b_rvalid), 64'd0);
    chk("rst_a_err",    64'(bus.a_err),    64'd0);
    chk("rst_b_err",    64'(bus.b_err),    64'd0);
    chk("rst_a_rdata",  64'(bus.a_rdata),  64'd0);
    chk("rst_b_rdata",  64'(bus.b_rdata),  64'd0);
  endtask

  // Response monitor: pops the scoreboard when a response falls due.
  initial begin
    forever begin
      @(negedge clk);
      if (qa.size() > 0 && qa[0].due == cyc) begin
        chk("a_rvalid", 64'(bus.a_rvalid), 64'd1);
        chk("a_rdata",  64'(bus.a_rdata),  64'(qa[0].data));
        chk("a_err",    64'(bus.a_err),    64'(qa[0].err));
        void'(qa.pop_front());
      end else if (bus.a_rvalid) begin
        chk("a_rvalid_unexpected", 64'(bus.a_rvalid), 64'd0);
      end
      if (qb.size() > 0 && qb[0].due == cyc) begin
        chk("b_rvalid", 64'(bus.b_rvalid), 64'd1);
        chk("b_rdata",  64'(bus.b_rdata),  64'(qb[0].data));
        chk("b_err",    64'(bus.b_err),    64'(qb[0].err));
        void'(qb.pop_front());
      end else if (bus.b_rvalid) begin
        chk("b_rvalid_unexpected", 64'(bus.b_rvalid), 64'd0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1);
  end

  // Stimulus
  initial begin
    bus.a_req = 1'b0; bus.a_addr = '0;
    bus.b_req = 1'b0; bus.b_we = 1'b0; bus.b_be = '0; bus.b_addr = '0; bus.b_wdata = '0;
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset_outputs();
    rst = 1'b0;

    // Fill the array so the model knows every word.
    for (int i = 0; i < DEPTH; i++)
      drive(1'b0, 32'h0, 1'b1, 1'b1, 4'hF, BASE + 32'(4 * i), $urandom);

    // Fetch stream from the first three words.
    drive(1'b1, BASE + 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    drive(1'b1, BASE + 32'h4, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    drive(1'b1, BASE + 32'h8, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    idle(RL + 1);

    // Byte-strobed write followed directly by a read of the same word.
    drive(1'b0, 32'h0, 1'b1, 1'b1, 4'b0101, BASE + 32'h10, 32'hDEAD_BEEF);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 4'h0,    BASE + 32'h10, 32'h0);
    drive(1'b0, 32'h0, 1'b1, 1'b1, 4'b0000, BASE + 32'h14, 32'h1234_5678);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 4'h0,    BASE + 32'h14, 32'h0);
    idle(RL + 1);

    // Both ports requesting continuously: starvation limit forces A through.
    for (int i = 0; i < 15; i++)
      drive(1'b1, BASE + 32'(4 * i), 1'b1, 1'b0, 4'h0, BASE + 32'(4 * (i + 20)), 32'h0);
    idle(RL + 1);

    // Faulting accesses: out of range, misaligned, below base.
    drive(1'b0, 32'h0, 1'b1, 1'b0, 4'h0, BASE + 32'h400, 32'h0);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 4'h0, BASE + 32'h2,   32'h0);
    drive(1'b0, 32'h0, 1'b1, 1'b1, 4'hF, BASE + 32'h400, 32'hFFFF_FFFF);
    drive(1'b0, 32'h0, 1'b1, 1'b1, 4'hF, BASE + 32'h12,  32'hFFFF_FFFF);
    drive(1'b1, BASE - 32'h4, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 4'h0, BASE + 32'h0,  32'h0);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 4'h0, BASE + 32'h10, 32'h0);
    idle(RL + 1);

    // Back-to-back reads give back-to-back responses.
    for (int i = 0; i < 5; i++)
      drive(1'b0, 32'h0, 1'b1, 1'b0, 4'h0, BASE + 32'(4 * $urandom_range(0, DEPTH - 1)), 32'h0);
    idle(RL + 1);

    // Random traffic on a small window to provoke write/read collisions.
    for (int i = 0; i < 2000; i++)
      drive($urandom_range(0, 9) < 6, rand_addr(16),
            $urandom_range(0, 9) < 6, 1'($urandom_range(0, 1)),
            4'($urandom_range(0, 15)), rand_addr(16), $urandom);
    idle(RL + 1);

    // Reset with two reads in flight and A already stalled twice.
    drive(1'b1, BASE + 32'h20, 1'b1, 1'b0, 4'h0, BASE + 32'h10, 32'h0);
    drive(1'b1, BASE + 32'h20, 1'b1, 1'b0, 4'h0, BASE + 32'h14, 32'h0);
    @(negedge clk);
    bus.a_req = 1'b0; bus.b_req = 1'b0;
    rst = 1'b1;
    qa.delete(); qb.delete();
    deny_cnt = 0;
    repeat (2) begin
      @(negedge clk);
      chk_reset_outputs();
    end
    rst = 1'b0;
    idle(RL + 2);
    for (int i = 0; i < 6; i++)
      drive(1'b1, BASE + 32'(4 * i), 1'b1, 1'b0, 4'h0, BASE + 32'h10, 32'h0);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 4'h0, BASE + 32'h14, 32'h0);
    idle(RL + 2);

    chk("a_queue_drained", 64'(qa.size()), 64'd0);
    chk("b_queue_drained", 64'(qb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
